variable_strobe_mc: RTL and testbench

Multi-channel, run-time programmable strobe generator. A shared period counter advances on a clock enable. Each channel emits a one-clock strobe at its own programmable phase within the period, plus a frame strobe at period wrap. Period and phase changes are staged and applied only at the period boundary, so no strobe is ever doubled or dropped mid-frame. Sits beside symbol/sample-rate logic, replacing fixed-period, fixed-phase strobe taps.

---
 rtl/variable_strobe_mc_if.sv | 31 +++
 rtl/variable_strobe_mc.sv | 117 +++++++++++
 tb/tb_variable_strobe_mc.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/variable_strobe_mc_if.sv
// Control/strobe bundle for variable_strobe_mc: count enable, staged period/phase
// loads, per-channel enables, and the registered strobe outputs.
interface variable_strobe_mc_if #(
  parameter int NCH        = 4,
  parameter int PERIOD_MAX = 20
);
  localparam int CW  = $clog2(PERIOD_MAX + 1);
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

  logic           en_i;
  logic           per_ld_i;
  logic [CW-1:0]  per_i;
  logic           ph_ld_i;
  logic [CHW-1:0] ph_ch_i;
  logic [CW-1:0]  ph_i;
  logic           ph_rdy_o;
  logic [NCH-1:0] ch_en_i;
  logic [NCH-1:0] stb_o;
  logic           frame_o;
  logic           err_o;

  modport master (
    output en_i, per_ld_i, per_i, ph_ld_i, ph_ch_i, ph_i, ch_en_i,
    input  ph_rdy_o, stb_o, frame_o, err_o
  );

  modport slave (
    input  en_i, per_ld_i, per_i, ph_ld_i, ph_ch_i, ph_i, ch_en_i,
    output ph_rdy_o, stb_o, frame_o, err_o
  );
endinterface

// File: rtl/variable_strobe_mc.sv
// Multi-channel strobe generator: shared period counter, per-channel phase taps,
// period/phase updates staged and applied only at the period wrap.
module variable_strobe_mc_lane #(
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          ch_en,
  input  logic          wrap,
  input  logic [CW-1:0] cnt,
  input  logic [CW-1:0] new_per,
  input  logic          ld,
  input  logic [CW-1:0] ld_val,
  output logic          stb,
  output logic          clamp
);
  logic [CW-1:0] ph_q;
  logic [CW-1:0] cand;

  // A phase landing at this wrap is clamped against the new frame's period too.
  assign cand  = ld ? ld_val : ph_q;
  assign clamp = wrap & (cand >= new_per);

  always_ff @(posedge clk) begin
    if (rst) begin
      ph_q <= '0;
      stb  <= 1'b0;
    end else begin
      stb <= en & ch_en & (cnt == ph_q);
      if (wrap) ph_q <= clamp ? (new_per - CW'(1)) : cand;
    end
  end
endmodule

module variable_strobe_mc #(
  parameter int NCH        = 4,
  parameter int PERIOD_MAX = 20,
  parameter int PERIOD_DEF = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  variable_strobe_mc_if.slave  bus
);
  localparam int CW  = $clog2(PERIOD_MAX + 1);
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [CW-1:0]  cnt, per_q, per_pend, new_per;
  logic           per_pend_vld;
  logic           ph_pend_vld;
  logic [CHW-1:0] ph_pend_ch;
  logic [CW-1:0]  ph_pend_val;
  logic           frame_q, err_q;
  logic           wrap, per_ok, ch_ok, ph_acc;
  logic [NCH-1:0] stb, clamp;

  assign wrap    = bus.en_i & (cnt == per_q - CW'(1));
  assign new_per = per_pend_vld ? per_pend : per_q;
  assign per_ok  = (bus.per_i >= CW'(2)) && (bus.per_i <= CW'(PERIOD_MAX));
  assign ch_ok   = int'(bus.ph_ch_i) < NCH;
  assign ph_acc  = bus.ph_ld_i & ~ph_pend_vld & ch_ok;

  for (genvar c = 0; c < NCH; c++) begin : g_lane
    variable_strobe_mc_lane #(.CW(CW)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .en      (bus.en_i),
      .ch_en   (bus.ch_en_i[c]),
      .wrap    (wrap),
      .cnt     (cnt),
      .new_per (new_per),
      .ld      (ph_pend_vld && (ph_pend_ch == CHW'(c))),
      .ld_val  (ph_pend_val),
      .stb     (stb[c]),
      .clamp   (clamp[c])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      per_q        <= CW'(PERIOD_DEF);
      per_pend     <= CW'(PERIOD_DEF);
      per_pend_vld <= 1'b0;
      ph_pend_vld  <= 1'b0;
      ph_pend_ch   <= '0;
      ph_pend_val  <= '0;
      frame_q      <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      frame_q <= wrap;
      err_q   <= (bus.per_ld_i & ~per_ok) | (|clamp);
      if (wrap)          cnt <= '0;
      else if (bus.en_i) cnt <= cnt + CW'(1);
      if (wrap) begin
        per_q        <= new_per;
        per_pend_vld <= 1'b0;
        ph_pend_vld  <= 1'b0;
      end
      // A load in the wrap cycle itself is staged for the following wrap.
      if (bus.per_ld_i && per_ok) begin
        per_pend     <= bus.per_i;
        per_pend_vld <= 1'b1;
      end
      if (ph_acc) begin
        ph_pend_ch  <= bus.ph_ch_i;
        ph_pend_val <= bus.ph_i;
        ph_pend_vld <= 1'b1;
      end
    end
  end

  assign bus.stb_o    = stb;
  assign bus.frame_o  = frame_q;
  assign bus.err_o    = err_q;
  assign bus.ph_rdy_o = ~ph_pend_vld;
endmodule

// File: tb/tb_variable_strobe_mc.sv
// Bench for variable_strobe_mc: frame-position model checked every cycle, plus
// directed scenarios with hand-counted strobe/frame/error totals.
module tb_variable_strobe_mc;
  localparam int NCH = 4;
  localparam int PMAX = 20;
  localparam int PDEF = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  variable_strobe_mc_if #(.NCH(NCH), .PERIOD_MAX(PMAX)) bus ();

  variable_strobe_mc #(.NCH(NCH), .PERIOD_MAX(PMAX), .PERIOD_DEF(PDEF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Model: position within the frame in enabled cycles, current period,
  // per-channel phase, and at most one staged period / phase (-1/0 = none).
  int   m_pos = 0, m_per = PDEF, m_pp = 0, m_phc = -1, m_phv = 0, m_np = 0;
  int   m_ph[NCH] = '{default: 0};
  bit   m_w, m_clamp, m_rej, m_old_rdy;
  logic [NCH-1:0] e_stb = '0;
  logic e_frame = 1'b0, e_err = 1'b0, e_rdy = 1'b1;

  always @(posedge clk) begin
    if (rst) begin
      m_pos = 0; m_per = PDEF; m_pp = 0; m_phc = -1; m_phv = 0;
      for (int c = 0; c < NCH; c++) m_ph[c] = 0;
      e_stb = '0; e_frame = 1'b0; e_err = 1'b0; e_rdy = 1'b1;
    end else begin
      m_old_rdy = (m_phc < 0);
      m_w = bus.en_i && (m_pos == m_per - 1);
      m_clamp = 1'b0;
      m_rej = 1'b0;
      for (int c = 0; c < NCH; c++)
        e_stb[c] = bus.en_i && bus.ch_en_i[c] && (m_pos == m_ph[c]);
      e_frame = m_w;
      if (m_w) begin
        m_np = (m_pp > 0) ? m_pp : m_per;
        if (m_phc >= 0) m_ph[m_phc] = m_phv;
        for (int c = 0; c < NCH; c++)
          if (m_ph[c] >= m_np) begin m_ph[c] = m_np - 1; m_clamp = 1'b1; end
        m_per = m_np; m_pp = 0; m_phc = -1; m_pos = 0;
      end else if (bus.en_i) begin
        m_pos = m_pos + 1;
      end
      if (bus.per_ld_i) begin
        if (int'(bus.per_i) >= 2 && int'(bus.per_i) <= PMAX) m_pp = int'(bus.per_i);
        else m_rej = 1'b1;
      end
      if (bus.ph_ld_i && m_old_rdy && int'(bus.ph_ch_i) < NCH) begin
        m_phc = int'(bus.ph_ch_i); m_phv = int'(bus.ph_i);
      end
      e_err = m_rej || m_clamp;
      e_rdy = (m_phc < 0);
    end
  end

  int errs = 0, checks = 0;
  int c_fr = 0, c_er = 0;
  int c_stb[NCH] = '{default: 0};

  task automatic clr();
    c_fr = 0; c_er = 0;
    for (int c = 0; c < NCH; c++) c_stb[c] = 0;
  endtask

  // One clock: outputs are compared against the model at the falling edge.
  task automatic cyc();
    @(negedge clk);
    checks++;
    if ({bus.stb_o, bus.frame_o, bus.err_o, bus.ph_rdy_o} !== {e_stb, e_frame, e_err, e_rdy}) begin
      errs++;
      $display("FAIL model t=%0t stb=%h exp %h frame=%b exp %b err=%b exp %b rdy=%b exp %b",
               $time, bus.stb_o, e_stb, bus.frame_o, e_frame, bus.err_o, e_err, bus.ph_rdy_o, e_rdy);
    end
    c_fr += int'(bus.frame_o);
    c_er += int'(bus.err_o);
    for (int c = 0; c < NCH; c++) c_stb[c] += int'(bus.stb_o[c]);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_pos(input int t);
    for (int n = 0; n < 100 && m_pos != t; n++) cyc();
    chk("wait_pos", m_pos, t);
  endtask

  task automatic wait_per(input int p);
    for (int n = 0; n < 100 && m_per != p; n++) cyc();
    chk("wait_per", m_per, p);
  endtask

  task automatic wait_rdy();
    for (int n = 0; n < 100 && bus.ph_rdy_o !== 1'b1; n++) cyc();
    chk("wait_rdy", int'(bus.ph_rdy_o), 1);
  endtask

  task automatic load_per(input int p);
    bus.per_ld_i = 1'b1; bus.per_i = 5'(p);
    cyc();
    bus.per_ld_i = 1'b0;
  endtask

  task automatic load_ph(input int ch, input int v);
    bus.ph_ld_i = 1'b1; bus.ph_ch_i = 2'(ch); bus.ph_i = 5'(v);
    cyc();
    bus.ph_ld_i = 1'b0;
  endtask

  initial begin
    bus.en_i = 1'b0; bus.per_ld_i = 1'b0; bus.per_i = '0;
    bus.ph_ld_i = 1'b0; bus.ph_ch_i = '0; bus.ph_i = '0; bus.ch_en_i = 4'hF;
    rst = 1'b1;
    run(3);
    chk("rst_rdy", int'(bus.ph_rdy_o), 1);
    chk("rst_stb", int'(bus.stb_o), 0);

    // Default period 20, all phases 0.
    rst = 1'b0; bus.en_i = 1'b1;
    clr(); run(40);
    chk("t1_frames", c_fr, 2);
    chk("t1_stb0", c_stb[0], 2);
    chk("t1_stb3", c_stb[3], 2);

    // Phase load ch2=7 at cnt 10; a second load while busy is ignored.
    wait_pos(10);
    load_ph(2, 7);
    chk("t2_rdy_low", int'(bus.ph_rdy_o), 0);
    clr();
    load_ph(1, 3);
    run(8);
    chk("t2_ch2_rest", c_stb[2], 0);
    chk("t2_wrap", c_fr, 1);
    chk("t2_rdy_back", int'(bus.ph_rdy_o), 1);
    clr(); run(20);
    chk("t2_ch2_next", c_stb[2], 1);
    chk("t2_ch1_next", c_stb[1], 1);

    // Period 5 loaded at cnt 3: current frame still ends at 20.
    wait_pos(3);
    load_per(5);
    clr(); run(16);
    chk("t3_old_frame", c_fr, 1);
    clr(); run(20);
    chk("t3_p5_frames", c_fr, 4);
    load_per(1);
    chk("t3_err_lo", int'(bus.err_o), 1);
    load_per(21);
    chk("t3_err_hi", int'(bus.err_o), 1);
    clr(); run(20);
    chk("t3_p_kept", c_fr, 4);
    chk("t3_no_err", c_er, 0);

    // ph1=15 under period 20, then period 8 clamps it to 7.
    load_per(20);
    wait_per(20);
    load_ph(1, 15);
    wait_rdy();
    load_per(8);
    clr(); run(25);
    chk("t4_clamp_err", c_er, 1);
    clr(); run(16);
    chk("t4_ch1", c_stb[1], 2);
    chk("t4_frames", c_fr, 2);

    // Period 4 with en toggling: frame every 8 clocks.
    load_per(4);
    wait_per(4);
    clr();
    for (int i = 0; i < 32; i++) begin
      bus.en_i = (i % 2 == 0);
      cyc();
    end
    chk("t5_frames", c_fr, 4);
    bus.en_i = 1'b1;

    // Reset at cnt 12 with a phase load pending.
    load_per(20);
    wait_per(20);
    load_ph(3, 9);
    wait_pos(12);
    chk("t6_pending", int'(bus.ph_rdy_o), 0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("t6_stb", int'(bus.stb_o), 0);
    chk("t6_frame", int'(bus.frame_o), 0);
    chk("t6_err", int'(bus.err_o), 0);
    chk("t6_rdy", int'(bus.ph_rdy_o), 1);
    clr(); run(40);
    chk("t6_frames", c_fr, 2);
    chk("t6_ch3", c_stb[3], 2);

    // Channel enables mask strobes without touching the counter.
    bus.ch_en_i = 4'b0101;
    clr(); run(20);
    chk("t7_ch1_off", c_stb[1], 0);
    chk("t7_ch0_on", c_stb[0], 1);
    chk("t7_frames", c_fr, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
